data_mem_ctrl: RTL and testbench

- Parametrised, byte-addressed data memory with a valid/ready request/response handshake and configurable access latency. It is the next generation of the LEGv8 data memory.
- It sits between the EX/MEM stage and the backing RAM array.
- Supported access sizes are byte, half, word and double, each with optional sign extension (LDURB/LDURH/LDURSW/LDUR, STURB/STURH/STURW/STUR).
- Misaligned and out-of-range accesses are flagged on the response; they never corrupt memory.

---
 rtl/data_mem_ctrl_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 37 +++
 rtl/data_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: default width,
// access size encodings and FSM state encodings.
package data_mem_ctrl_pkg;
   localparam int DMEM_WORD = 64;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for one RAM entry: extracts and extends load data,
// merges store bytes into the entry and flags misaligned addresses.
module dmem_lane_align
   import data_mem_ctrl_pkg::*;
#(
   parameter  int WORD = DMEM_WORD,
   localparam int LB   = $clog2(WORD / 8)
) (
   input  logic [WORD-1:0] entry,
   input  logic [LB-1:0]   lane,
   input  logic [1:0]      size,
   input  logic            sgn,
   input  logic [WORD-1:0] wdata,
   output logic [WORD-1:0] rdata,
   output logic [WORD-1:0] wentry,
   output logic            misaligned
);
   logic [WORD-1:0] mask;
   logic [WORD-1:0] lmask;
   logic [WORD-1:0] shifted;
   logic [LB+2:0]   bit_ofs;
   int              nbits;

   always_comb begin
      nbits = 8 << size;
      mask  = '1;
      if (nbits < WORD) mask = ~({WORD{1'b1}} << nbits);
      bit_ofs = {lane, 3'b000};
      shifted = entry >> bit_ofs;
      rdata   = shifted & mask;
      // mask ^ (mask >> 1) isolates the sign bit of the access
      if (sgn && (|(rdata & (mask ^ (mask >> 1))))) rdata = rdata | ~mask;
      lmask      = mask << bit_ofs;
      wentry     = (entry & ~lmask) | ((wdata << bit_ofs) & lmask);
      misaligned = (int'(lane) & ((1 << size) - 1)) != 0;
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with valid/ready handshake and fixed access
// latency. The array access happens on the edge that enters RESP.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int WORD    = DMEM_WORD,
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 64,
   parameter int LATENCY = 1
) (
   input  logic              im_clk,
   input  logic              im_rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [WORD-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD-1:0]   rsp_rdata,
   output logic              rsp_err
);
   localparam int NB = WORD / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              a_write, a_signed;
   logic [ADDR_W-1:0] a_addr;
   logic [1:0]        a_size;
   logic [WORD-1:0]   a_wdata;
   logic [WORD-1:0]   mem [DEPTH];

   logic              accept, do_access;
   logic              x_write, x_signed;
   logic [ADDR_W-1:0] x_addr;
   logic [1:0]        x_size;
   logic [WORD-1:0]   x_wdata;
   logic [IW-1:0]     idx;
   logic              in_range, oversize, misaligned, err;
   logic [WORD-1:0]   entry, ld_data, st_entry;

   assign accept    = req_ready && req_valid;
   assign do_access = im_rst_n && ((accept && LATENCY == 1) || (state == ST_WAIT && cnt == 4'd0));

   // With LATENCY=1 the access uses the live request, otherwise the latched one
   always_comb begin
      if (state == ST_IDLE) begin
         x_write = req_write; x_signed = req_signed; x_addr = req_addr;
         x_size  = req_size;  x_wdata  = req_wdata;
      end else begin
         x_write = a_write;   x_signed = a_signed;   x_addr = a_addr;
         x_size  = a_size;    x_wdata  = a_wdata;
      end
   end

   assign in_range = (x_addr >> LB) < ADDR_W'(DEPTH);
   assign oversize = (1 << x_size) > NB;
   assign idx      = x_addr[LB +: IW];
   assign entry    = in_range ? mem[idx] : '0;
   assign err      = !in_range || oversize || misaligned;

   dmem_lane_align #(.WORD(WORD)) u_align (
      .entry      (entry),
      .lane       (x_addr[LB-1:0]),
      .size       (x_size),
      .sgn        (x_signed),
      .wdata      (x_wdata),
      .rdata      (ld_data),
      .wentry     (st_entry),
      .misaligned (misaligned)
   );

   always_ff @(posedge im_clk or negedge im_rst_n) begin
      if (!im_rst_n) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = im_rst_n && (state == ST_IDLE);
      rsp_valid = (state == ST_RESP);
   end

   always_ff @(posedge im_clk or negedge im_rst_n) begin
      if (!im_rst_n) begin
         cnt       <= '0;
         a_write   <= 1'b0;
         a_signed  <= 1'b0;
         a_addr    <= '0;
         a_size    <= '0;
         a_wdata   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            a_write  <= req_write;
            a_signed <= req_signed;
            a_addr   <= req_addr;
            a_size   <= req_size;
            a_wdata  <= req_wdata;
            cnt      <= 4'((LATENCY >= 2) ? LATENCY - 2 : 0);
         end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (do_access) begin
            rsp_rdata <= (x_write || err) ? '0 : ld_data;
            rsp_err   <= err;
         end
      end
   end

   // RAM contents survive reset; an errored access never writes
   always_ff @(posedge im_clk) begin
      if (do_access && x_write && !err) mem[idx] <= st_entry;
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: two controllers (LATENCY 1 and 4) driven with directed
// and random traffic, checked against a byte-array reference memory.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
   localparam int NB_MEM = 256;  // DEPTH 32 x 8 bytes

   typedef struct {
      int          d;
      logic [63:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic        im_clk = 1'b0;
   logic        im_rst_n = 1'b0;
   logic        req_valid[2], req_ready[2], req_write[2], req_signed[2];
   logic        rsp_valid[2], rsp_ready[2], rsp_err[2];
   logic [63:0] req_addr[2], req_wdata[2], rsp_rdata[2];
   logic [1:0]  req_size[2];

   logic [7:0]  mm [2][NB_MEM];
   exp_t        sbq[$];
   int          total = 0, bad = 0, cyc = 0;
   int          hold[2];
   logic        prev_v[2];
   logic [63:0] held_d[2];
   logic        held_e[2];

   always #5 im_clk = ~im_clk;
   always @(posedge im_clk) cyc <= cyc + 1;

   data_mem_ctrl #(.WORD(64), .DEPTH(32), .ADDR_W(64), .LATENCY(1)) dut1 (
      .im_clk(im_clk), .im_rst_n(im_rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   data_mem_ctrl #(.WORD(64), .DEPTH(32), .ADDR_W(64), .LATENCY(4)) dut4 (
      .im_clk(im_clk), .im_rst_n(im_rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, want, $time);
      end
   endtask

   // Reference memory: plain byte array, little-endian accesses
   task automatic model(input int d, input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] wd, output logic [63:0] rd, output logic er);
      int nb, a;
      logic [63:0] v;
      nb = 1 << sz;
      er = ((addr % 64'(nb)) != 0) || (addr >= 64'(NB_MEM));
      rd = '0;
      if (!er) begin
         a = int'(addr);
         if (wr) begin
            for (int i = 0; i < nb; i++) mm[d][a+i] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = nb - 1; i >= 0; i--) v = (v << 8) | 64'(mm[d][a+i]);
            if (sg && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
            rd = v;
         end
      end
   endtask

   task automatic issue(input int d, input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] wd, input bit expect_rsp);
      exp_t e;
      int   n;
      @(negedge im_clk);
      req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
      req_size[d] = sz; req_signed[d] = sg; req_wdata[d] = wd;
      n = 0;
      while (!req_ready[d] && n < 100) begin
         @(negedge im_clk);
         n++;
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL accept_timeout dut%0d: req_ready stayed %b, expected 1", d, req_ready[d]);
         req_valid[d] = 1'b0;
         return;
      end
      e.d = d;
      e.acc = cyc + 1;
      if (expect_rsp) begin
         model(d, wr, addr, sz, sg, wd, e.rdata, e.err);
         sbq.push_back(e);
      end
      @(posedge im_clk);
      #1 req_valid[d] = 1'b0;
   endtask

   task automatic rsp_drv(input int d);
      forever begin
         @(negedge im_clk);
         if (rsp_valid[d] && hold[d] > 0) begin
            rsp_ready[d] = 1'b0;
            hold[d]--;
         end else begin
            rsp_ready[d] = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(negedge im_clk);
         n++;
      end
      if (sbq.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   // Monitor: pops on each new response, checks hold-stability while stalled
   always @(negedge im_clk) begin : mon
      int   k;
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rsp_valid[d] && !prev_v[d]) begin
            k = -1;
            foreach (sbq[i]) if (k < 0 && sbq[i].d == d) k = i;
            if (k < 0) begin
               total++; bad++;
               $display("FAIL unexpected_rsp dut%0d: rdata=%h err=%b with no request outstanding",
                        d, rsp_rdata[d], rsp_err[d]);
            end else begin
               e = sbq[k];
               sbq.delete(k);
               chk("rdata", d, rsp_rdata[d], e.rdata);
               chk("err", d, 64'(rsp_err[d]), 64'(e.err));
               chk("latency", d, 64'(cyc - e.acc + 1), 64'(lat(d)));
            end
            held_d[d] = rsp_rdata[d];
            held_e[d] = rsp_err[d];
         end else if (rsp_valid[d] && prev_v[d]) begin
            chk("hold_rdata", d, rsp_rdata[d], held_d[d]);
            chk("hold_err", d, 64'(rsp_err[d]), 64'(held_e[d]));
            chk("hold_req_ready", d, 64'(req_ready[d]), 64'd0);
         end
         prev_v[d] = rsp_valid[d];
      end
   end

   initial begin
      #500000;
      total++; bad++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] a;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_write[d] = 1'b0; req_signed[d] = 1'b0;
         req_addr[d] = '0; req_wdata[d] = '0; req_size[d] = '0;
         rsp_ready[d] = 1'b0; hold[d] = 0; prev_v[d] = 1'b0;
         held_d[d] = '0; held_e[d] = 1'b0;
      end
      im_rst_n = 1'b0;
      repeat (3) @(negedge im_clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready_low", d, 64'(req_ready[d]), 64'd0);
         chk("rst_rsp_valid", d, 64'(rsp_valid[d]), 64'd0);
      end
      im_rst_n = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("idle_req_ready", d, 64'(req_ready[d]), 64'd1);
         chk("idle_rsp_valid", d, 64'(rsp_valid[d]), 64'd0);
         chk("idle_rsp_rdata", d, rsp_rdata[d], 64'd0);
         chk("idle_rsp_err", d, 64'(rsp_err[d]), 64'd0);
      end
      fork
         rsp_drv(0);
         rsp_drv(1);
      join_none

      // Fill both arrays so every later load has a known reference value
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32; i++)
            issue(d, 1'b1, 64'(i * 8), 2'd3, 1'b0, {$urandom, $urandom}, 1'b1);
      drain();

      // Directed LATENCY=1 sequence
      issue(0, 1'b1, 64'h10, 2'd3, 1'b0, 64'h0123456789ABCDEF, 1'b1);
      issue(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 1'b1);
      issue(0, 1'b1, 64'h13, 2'd0, 1'b0, 64'h80, 1'b1);
      issue(0, 1'b0, 64'h13, 2'd0, 1'b1, 64'h0, 1'b1);
      issue(0, 1'b0, 64'h13, 2'd0, 1'b0, 64'h0, 1'b1);
      issue(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 1'b1);
      issue(0, 1'b0, 64'h11, 2'd1, 1'b1, 64'h0, 1'b1);
      issue(0, 1'b1, 64'h100, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      issue(0, 1'b0, 64'h0, 2'd3, 1'b0, 64'h0, 1'b1);
      issue(0, 1'b1, 64'h8000_0000_0000_0008, 2'd3, 1'b0, 64'h5555, 1'b1);
      issue(0, 1'b0, 64'h8, 2'd3, 1'b0, 64'h0, 1'b1);
      drain();

      // Backpressure on the LATENCY=4 instance: five stalled cycles each
      hold[1] = 5;
      issue(1, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 1'b1);
      drain();
      hold[1] = 5;
      issue(1, 1'b1, 64'h11, 2'd1, 1'b0, 64'hBEEF, 1'b1);
      drain();

      // Random traffic on both instances
      for (int n = 0; n < 150; n++) begin
         for (int d = 0; d < 2; d++) begin
            case ($urandom_range(0, 9))
               0:       a = {1'b1, 31'($urandom), 32'($urandom)};
               1:       a = 64'($urandom_range(256, 300));
               default: a = 64'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 19) == 0) hold[d] = int'($urandom_range(1, 6));
            issue(d, 1'($urandom), a, 2'($urandom), 1'($urandom), {$urandom, $urandom}, 1'b1);
         end
      end
      drain();

      // Reset in WAIT aborts the store to 0x8: no response, entry 1 keeps its value
      issue(1, 1'b1, 64'h8, 2'd3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
      @(posedge im_clk);
      @(negedge im_clk);
      im_rst_n = 1'b0;
      #1;
      chk("abort_req_ready", 1, 64'(req_ready[1]), 64'd0);
      chk("abort_rsp_valid", 1, 64'(rsp_valid[1]), 64'd0);
      chk("abort_rsp_rdata", 1, rsp_rdata[1], 64'd0);
      repeat (2) @(negedge im_clk);
      chk("abort_still_idle", 1, 64'(rsp_valid[1]), 64'd0);
      im_rst_n = 1'b1;
      #1;
      chk("abort_req_ready_back", 1, 64'(req_ready[1]), 64'd1);
      issue(1, 1'b0, 64'h8, 2'd3, 1'b0, 64'h0, 1'b1);
      issue(1, 1'b0, 64'hC, 2'd2, 1'b1, 64'h0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
